// File: rtl/vga_scan_mouse_controller_pkg.sv
// Shared VGA timing constants, vertical state encoding and the cursor clamp helper.
// Default timing is 640x480@60 (800x525 total).
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CURSOR_SIZE  = 20;
  localparam int MOUSE_INIT_X = 310;
  localparam int MOUSE_INIT_Y = 230;

  typedef enum logic [1:0] {
    VS_ACTIVE,
    VS_FRONT,
    VS_SYNC,
    VS_BACK
  } vstate_t;

  // Saturate a signed 12-bit sum into the unsigned range [0, hi].
  function automatic logic [10:0] clamp(input logic signed [11:0] v,
                                        input logic signed [11:0] hi);
    if (v < 12'sd0) begin
      return 11'd0;
    end else if (v > hi) begin
      return hi[10:0];
    end else begin
      return v[10:0];
    end
  endfunction

endpackage

// File: rtl/vga_scan_mouse_controller_if.sv
// Mouse movement packet handshake between the PS/2 decoder (master) and the controller (slave).
interface vga_scan_mouse_controller_if;
  logic              move_valid;
  logic signed [8:0] move_dx;
  logic signed [8:0] move_dy;
  logic              move_ready;

  modport master (output move_valid, output move_dx, output move_dy, input move_ready);
  modport slave  (input move_valid, input move_dx, input move_dy, output move_ready);
endinterface

// File: rtl/vga_scan_mouse_controller_tracker.sv
// Cursor accumulator: clamps each accepted packet into the pending position and
// copies it to the visible position on the frame-boundary commit strobe.
module vga_mouse_tracker
  import vga_timing_pkg::*;
#(
  parameter int X_MAX  = vga_timing_pkg::H_ACTIVE - vga_timing_pkg::CURSOR_SIZE,
  parameter int Y_MAX  = vga_timing_pkg::V_ACTIVE - vga_timing_pkg::CURSOR_SIZE,
  parameter int INIT_X = vga_timing_pkg::MOUSE_INIT_X,
  parameter int INIT_Y = vga_timing_pkg::MOUSE_INIT_Y
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         commit,
  vga_scan_mouse_controller_if.slave   mv,
  output logic [10:0]                  mouse_x,
  output logic [10:0]                  mouse_y
);

  logic [10:0]        pend_x_reg;
  logic [10:0]        pend_y_reg;
  logic [10:0]        mouse_x_reg;
  logic [10:0]        mouse_y_reg;
  logic               accept;
  logic signed [11:0] sum_x;
  logic signed [11:0] sum_y;

  // Refusing packets on the commit clk keeps pend stable while it is copied.
  assign mv.move_ready = !reset && !commit;
  assign accept        = mv.move_valid && mv.move_ready;

  // Screen Y grows downward while mouse dy is positive-up, hence the subtraction.
  assign sum_x = $signed({1'b0, pend_x_reg}) + $signed({{3{mv.move_dx[8]}}, mv.move_dx});
  assign sum_y = $signed({1'b0, pend_y_reg}) - $signed({{3{mv.move_dy[8]}}, mv.move_dy});

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_x_reg  <= 11'(INIT_X);
      pend_y_reg  <= 11'(INIT_Y);
      mouse_x_reg <= 11'(INIT_X);
      mouse_y_reg <= 11'(INIT_Y);
    end else begin
      if (accept) begin
        pend_x_reg <= clamp(sum_x, 12'(X_MAX));
        pend_y_reg <= clamp(sum_y, 12'(Y_MAX));
      end
      if (commit) begin
        mouse_x_reg <= pend_x_reg;
        mouse_y_reg <= pend_y_reg;
      end
    end
  end

  assign mouse_x = mouse_x_reg;
  assign mouse_y = mouse_y_reg;

endmodule

// File: rtl/vga_scan_mouse_controller.sv
// VGA scan timing plus frame-synchronous mouse cursor position.
// Define VGA_SYNC_DELAY_EN to add one pix_ce register stage on hsync/vsync/video_active.
module vga_scan_mouse_controller #(
  parameter int H_ACTIVE     = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP         = vga_timing_pkg::H_FP,
  parameter int H_SYNC       = vga_timing_pkg::H_SYNC,
  parameter int H_BP         = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE     = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP         = vga_timing_pkg::V_FP,
  parameter int V_SYNC       = vga_timing_pkg::V_SYNC,
  parameter int V_BP         = vga_timing_pkg::V_BP,
  parameter int CURSOR_SIZE  = vga_timing_pkg::CURSOR_SIZE,
  parameter int MOUSE_INIT_X = vga_timing_pkg::MOUSE_INIT_X,
  parameter int MOUSE_INIT_Y = vga_timing_pkg::MOUSE_INIT_Y
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pix_ce,
  vga_scan_mouse_controller_if.slave   mv,
  output logic [9:0]                   xPixel,
  output logic [8:0]                   yPixel,
  output logic                         video_active,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         frame_start,
  output logic [10:0]                  mouseX,
  output logic [10:0]                  mouseY
);

  import vga_timing_pkg::*;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;

  logic [9:0] h_cnt_reg, h_cnt_next;
  logic [9:0] v_cnt_reg, v_cnt_next;
  vstate_t    vstate_reg, vstate_next;
  logic       line_end;
  logic       commit;
  logic       active_now, hsync_now, vsync_now;

  logic [9:0] x_pixel_reg;
  logic [8:0] y_pixel_reg;
  logic       video_active_reg, hsync_reg, vsync_reg;

  assign line_end = (h_cnt_reg == 10'(H_TOTAL - 1));
  // The commit clk is the pix_ce that starts the first blanking line.
  assign commit      = pix_ce && !reset && (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'(V_ACTIVE));
  assign frame_start = commit;

  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (pix_ce) begin
      if (line_end) begin
        h_cnt_next = 10'd0;
        v_cnt_next = (v_cnt_reg == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt_reg + 10'd1;
      end else begin
        h_cnt_next = h_cnt_reg + 10'd1;
      end
    end
  end

  always_comb begin
    vstate_next = vstate_reg;
    if (pix_ce && line_end) begin
      case (vstate_reg)
        VS_ACTIVE: if (v_cnt_reg == 10'(V_ACTIVE - 1))                   vstate_next = VS_FRONT;
        VS_FRONT:  if (v_cnt_reg == 10'(V_ACTIVE + V_FP - 1))            vstate_next = VS_SYNC;
        VS_SYNC:   if (v_cnt_reg == 10'(V_ACTIVE + V_FP + V_SYNC - 1))   vstate_next = VS_BACK;
        VS_BACK:   if (v_cnt_reg == 10'(V_TOTAL - 1))                    vstate_next = VS_ACTIVE;
        default:                                                         vstate_next = VS_ACTIVE;
      endcase
    end
    active_now = (h_cnt_reg < 10'(H_ACTIVE)) && (vstate_reg == VS_ACTIVE);
    hsync_now  = !((h_cnt_reg >= 10'(HS_START)) && (h_cnt_reg < 10'(HS_END)));
    vsync_now  = (vstate_reg != VS_SYNC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_reg        <= 10'd0;
      v_cnt_reg        <= 10'd0;
      vstate_reg       <= VS_ACTIVE;
      x_pixel_reg      <= 10'd0;
      y_pixel_reg      <= 9'd0;
      video_active_reg <= 1'b0;
      hsync_reg        <= 1'b1;
      vsync_reg        <= 1'b1;
    end else if (pix_ce) begin
      h_cnt_reg        <= h_cnt_next;
      v_cnt_reg        <= v_cnt_next;
      vstate_reg       <= vstate_next;
      x_pixel_reg      <= active_now ? h_cnt_reg : 10'd0;
      y_pixel_reg      <= active_now ? v_cnt_reg[8:0] : 9'd0;
      video_active_reg <= active_now;
      hsync_reg        <= hsync_now;
      vsync_reg        <= vsync_now;
    end
  end

  assign xPixel = x_pixel_reg;
  assign yPixel = y_pixel_reg;

`ifdef VGA_SYNC_DELAY_EN
  // Extra stage lines sync/blank up with a registered RGB path.
  logic hsync_dly_reg, vsync_dly_reg, video_active_dly_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_dly_reg        <= 1'b1;
      vsync_dly_reg        <= 1'b1;
      video_active_dly_reg <= 1'b0;
    end else if (pix_ce) begin
      hsync_dly_reg        <= hsync_reg;
      vsync_dly_reg        <= vsync_reg;
      video_active_dly_reg <= video_active_reg;
    end
  end

  assign hsync        = hsync_dly_reg;
  assign vsync        = vsync_dly_reg;
  assign video_active = video_active_dly_reg;
`else
  assign hsync        = hsync_reg;
  assign vsync        = vsync_reg;
  assign video_active = video_active_reg;
`endif

  vga_mouse_tracker #(
    .X_MAX  (H_ACTIVE - CURSOR_SIZE),
    .Y_MAX  (V_ACTIVE - CURSOR_SIZE),
    .INIT_X (MOUSE_INIT_X),
    .INIT_Y (MOUSE_INIT_Y)
  ) u_tracker (
    .clk     (clk),
    .reset   (reset),
    .commit  (commit),
    .mv      (mv),
    .mouse_x (mouseX),
    .mouse_y (mouseY)
  );

endmodule
